// File: rtl/eth_cmd_rx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// eth_cmd_rx_fifo_pkg
// Shared definitions for the Ethernet receive byte FIFO feeding the
// PacoBlaze housekeeping core: write FSM encoding, length header width and
// the cpu port numbers used by firmware to reach this block.
// ---------------------------------------------------------------------------
package eth_cmd_rx_fifo_pkg;

   localparam int unsigned LEN_W  = 16;  // big-endian frame length header
   localparam int unsigned BYTE_W = 8;

   // PacoBlaze port map for the receive byte port
   localparam logic [7:0] PORT_ETH_RX_DATA  = 8'd50;
   localparam logic [7:0] PORT_ETH_RX_READY = 8'd51;
   localparam logic [7:0] PORT_ETH_RX_READ  = 8'd48;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RECV      = 3'd1,
      ST_DROP      = 3'd2,
      ST_COMMIT_HI = 3'd3,
      ST_COMMIT_LO = 3'd4
   } wr_state_t;

endpackage

// File: rtl/eth_cmd_rx_fifo_ram.sv
// ---------------------------------------------------------------------------
// eth_cmd_ram
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Written to infer a block RAM (no reset on storage or read register).
// Ports:
//   clk      clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address (sampled every cycle)
//   o_rdata  registered read data (old contents on same-address write)
// ---------------------------------------------------------------------------
module eth_cmd_ram #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [0:DEPTH-1];
   logic [DATA_W-1:0] r_rdata;

   // write and registered read share one clock
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/eth_cmd_rx_fifo.sv
// ---------------------------------------------------------------------------
// eth_cmd_rx_fifo
// Stores good MAC receive frames, each preceded by a 2-byte big-endian
// payload length, and hands them byte by byte to the PacoBlaze core.
// Bad, oversize, overflowing or aborted frames are rolled back and counted.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   in_data         MAC receive byte
//   in_valid        in_data valid this cycle
//   in_sof/in_eof   first/last byte of frame (qualified by in_valid)
//   in_err          frame bad, sampled on the eof beat
//   eth_rx_data     byte at head of buffer (holds last value when empty)
//   eth_rx_ready    buffer holds at least one committed byte
//   eth_rx_read     cpu port level; rising edge pops one byte
//   drop_count      saturating count of discarded frames
// ---------------------------------------------------------------------------
module eth_cmd_rx_fifo
   import eth_cmd_rx_fifo_pkg::*;
#(
   parameter int unsigned ADDR_W  = 11,
   parameter int unsigned MAX_LEN = 1500
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_sof,
   input  logic              in_eof,
   input  logic              in_err,
   output logic [BYTE_W-1:0] eth_rx_data,
   output logic              eth_rx_ready,
   input  logic              eth_rx_read,
   output logic [7:0]        drop_count
);

   wr_state_t          r_state, w_state_nxt;
   logic [ADDR_W-1:0]  r_rd_ptr, r_com_ptr, r_wr_ptr, r_hdr_ptr;
   logic [ADDR_W-1:0]  w_com_ptr_nxt, w_wr_ptr_nxt, w_hdr_ptr_nxt;
   logic [LEN_W-1:0]   r_len, w_len_nxt;
   logic               r_skip, w_skip_nxt;
   logic [1:0]         w_drops;
   logic [7:0]         r_drop_count;
   logic [8:0]         w_drop_sum;
   logic               r_rd_prev, r_nonempty, r_rx_ready;
   logic [BYTE_W-1:0]  r_rx_data;

   logic               w_we;
   logic [ADDR_W-1:0]  w_waddr;
   logic [BYTE_W-1:0]  w_wdata;
   logic [BYTE_W-1:0]  w_ram_q;

   logic               w_start;
   logic               w_sof_beat;
   logic               w_len_over;
   logic               w_wr_full;
   logic [ADDR_W-1:0]  w_free;
   logic               w_hdr_room;
   logic               w_pop;

   assign w_sof_beat = in_valid & in_sof;
   assign w_len_over = (r_len >= LEN_W'(MAX_LEN));
   // writing at wr_ptr would make the buffer completely full
   assign w_wr_full  = ((r_wr_ptr + ADDR_W'(1)) == r_rd_ptr);
   // free bytes ahead of com_ptr; a new frame needs header + first byte
   assign w_free     = r_rd_ptr - r_com_ptr - ADDR_W'(1);
   assign w_hdr_room = (w_free >= ADDR_W'(3));
   assign w_pop      = eth_rx_read & ~r_rd_prev & (r_rd_ptr != r_com_ptr);

   // write FSM next-state and RAM write port
   always_comb begin
      w_state_nxt   = r_state;
      w_wr_ptr_nxt  = r_wr_ptr;
      w_hdr_ptr_nxt = r_hdr_ptr;
      w_com_ptr_nxt = r_com_ptr;
      w_len_nxt     = r_len;
      w_skip_nxt    = r_skip;
      w_drops       = 2'd0;
      w_we          = 1'b0;
      w_waddr       = r_wr_ptr;
      w_wdata       = in_data;
      w_start       = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_sof_beat) begin
               w_start = 1'b1;
            end
         end
         ST_RECV: begin
            if (in_valid) begin
               if (in_sof) begin
                  w_drops = 2'd1;
                  w_start = 1'b1;
               end else if (w_len_over || w_wr_full) begin
                  w_wr_ptr_nxt = r_com_ptr;
                  if (in_eof) begin
                     w_drops     = 2'd1;
                     w_state_nxt = ST_IDLE;
                  end else begin
                     w_state_nxt = ST_DROP;
                  end
               end else if (in_eof && in_err) begin
                  w_drops      = 2'd1;
                  w_wr_ptr_nxt = r_com_ptr;
                  w_state_nxt  = ST_IDLE;
               end else begin
                  w_we         = 1'b1;
                  w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
                  w_len_nxt    = r_len + LEN_W'(1);
                  if (in_eof) begin
                     w_state_nxt = ST_COMMIT_HI;
                  end
               end
            end
         end
         ST_DROP: begin
            if (in_valid) begin
               if (in_sof) begin
                  w_drops = 2'd1;
                  w_start = 1'b1;
               end else if (in_eof) begin
                  w_drops      = 2'd1;
                  w_wr_ptr_nxt = r_com_ptr;
                  w_state_nxt  = ST_IDLE;
               end
            end
         end
         ST_COMMIT_HI: begin
            w_we        = 1'b1;
            w_waddr     = r_hdr_ptr;
            w_wdata     = r_len[15:8];
            w_state_nxt = ST_COMMIT_LO;
            // a frame starting here cannot be stored; remember to skip it
            if (w_sof_beat) begin
               if (in_eof) begin
                  w_drops = 2'd1;
               end else begin
                  w_skip_nxt = 1'b1;
               end
            end
         end
         ST_COMMIT_LO: begin
            w_we          = 1'b1;
            w_waddr       = r_hdr_ptr + ADDR_W'(1);
            w_wdata       = r_len[7:0];
            w_com_ptr_nxt = r_wr_ptr;
            w_state_nxt   = ST_IDLE;
            w_skip_nxt    = 1'b0;
            if (r_skip || w_sof_beat) begin
               if (in_valid && in_eof) begin
                  w_drops = 2'd1;
               end else begin
                  w_state_nxt = ST_DROP;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // frame start, shared by IDLE and the sof-restart paths
      if (w_start) begin
         w_hdr_ptr_nxt = r_com_ptr;
         w_wr_ptr_nxt  = r_com_ptr;
         if (!w_hdr_room) begin
            if (in_eof) begin
               w_drops     = w_drops + 2'd1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_DROP;
            end
         end else if (in_eof && in_err) begin
            w_drops     = w_drops + 2'd1;
            w_state_nxt = ST_IDLE;
         end else begin
            w_we         = 1'b1;
            w_waddr      = r_com_ptr + ADDR_W'(2);
            w_wdata      = in_data;
            w_wr_ptr_nxt = r_com_ptr + ADDR_W'(3);
            w_len_nxt    = LEN_W'(1);
            w_state_nxt  = in_eof ? ST_COMMIT_HI : ST_RECV;
         end
      end
   end

   assign w_drop_sum = {1'b0, r_drop_count} + 9'(w_drops);

   // write-side state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_wr_ptr     <= '0;
         r_hdr_ptr    <= '0;
         r_com_ptr    <= '0;
         r_len        <= '0;
         r_skip       <= 1'b0;
         r_drop_count <= 8'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_wr_ptr     <= w_wr_ptr_nxt;
         r_hdr_ptr    <= w_hdr_ptr_nxt;
         r_com_ptr    <= w_com_ptr_nxt;
         r_len        <= w_len_nxt;
         r_skip       <= w_skip_nxt;
         r_drop_count <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      end
   end

   // read side: pop on rising edge of the cpu level, two-stage output
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr   <= '0;
         r_rd_prev  <= 1'b0;
         r_nonempty <= 1'b0;
         r_rx_ready <= 1'b0;
         r_rx_data  <= '0;
      end else begin
         r_rd_prev  <= eth_rx_read;
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         end
         r_nonempty <= (r_rd_ptr != r_com_ptr);
         r_rx_ready <= r_nonempty;
         // RAM output is aligned with r_nonempty; hold last byte when empty
         if (r_nonempty) begin
            r_rx_data <= w_ram_q;
         end
      end
   end

   eth_cmd_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (BYTE_W)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_ram_q)
   );

   assign eth_rx_data  = r_rx_data;
   assign eth_rx_ready = r_rx_ready;
   assign drop_count   = r_drop_count;

endmodule

// File: tb/tb_eth_cmd_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_eth_cmd_rx_fifo
// Directed bench: a full-size instance (depth 2048) and a depth-16 instance
// for wrap/overflow, selected by 'sel'. Expected values are hand-derived.
// ---------------------------------------------------------------------------
module tb_eth_cmd_rx_fifo;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [7:0] in_data;
   logic       in_valid, in_sof, in_eof, in_err;
   logic       rd;
   logic       sel;

   logic       b_valid, s_valid, b_read, s_read;
   logic [7:0] b_data, s_data, b_drop, s_drop;
   logic       b_ready, s_ready;
   logic [7:0] obs_data, obs_drop;
   logic       obs_ready;

   int n_cmp  = 0;
   int n_fail = 0;

   assign b_valid   = in_valid & ~sel;
   assign s_valid   = in_valid & sel;
   assign b_read    = rd & ~sel;
   assign s_read    = rd & sel;
   assign obs_data  = sel ? s_data  : b_data;
   assign obs_ready = sel ? s_ready : b_ready;
   assign obs_drop  = sel ? s_drop  : b_drop;

   eth_cmd_rx_fifo dut (
      .clk          (clk),
      .reset        (reset),
      .in_data      (in_data),
      .in_valid     (b_valid),
      .in_sof       (in_sof),
      .in_eof       (in_eof),
      .in_err       (in_err),
      .eth_rx_data  (b_data),
      .eth_rx_ready (b_ready),
      .eth_rx_read  (b_read),
      .drop_count   (b_drop)
   );

   eth_cmd_rx_fifo #(.ADDR_W(4)) dut_small (
      .clk          (clk),
      .reset        (reset),
      .in_data      (in_data),
      .in_valid     (s_valid),
      .in_sof       (in_sof),
      .in_eof       (in_eof),
      .in_err       (in_err),
      .eth_rx_data  (s_data),
      .eth_rx_ready (s_ready),
      .eth_rx_read  (s_read),
      .drop_count   (s_drop)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_byte(input logic [7:0] d, input logic sof, input logic eof, input logic err);
      in_valid = 1'b1; in_data = d; in_sof = sof; in_eof = eof; in_err = err;
      tick();
      in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_err = 1'b0;
   endtask

   // bytes first, first+step, first+2*step, ... ; err flagged on the eof beat
   task automatic send_frame(input int len, input logic [7:0] first, input logic [7:0] step,
                             input logic err);
      logic [7:0] d;
      d = first;
      for (int i = 0; i < len; i++) begin
         send_byte(d, i == 0, i == len - 1, (i == len - 1) ? err : 1'b0);
         d = d + step;
      end
   endtask

   // capture head byte, then one rising edge on the read level
   task automatic read_byte(output logic [7:0] d);
      d  = obs_data;
      rd = 1'b1;
      tick();
      rd = 1'b0;
      wait_cycles(4);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      wait_cycles(3);
      reset = 1'b0;
      tick();
      n_cmp++; if (b_data !== 8'h00)  begin n_fail++; $display("FAIL reset_data got=%h exp=00", b_data); end
      n_cmp++; if (b_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_ready got=%b exp=0", b_ready); end
      n_cmp++; if (b_drop !== 8'h00)  begin n_fail++; $display("FAIL reset_drop got=%h exp=00", b_drop); end
      n_cmp++; if (s_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_small_ready got=%b exp=0", s_ready); end
   endtask

   task automatic test_good_frame();
      logic [7:0] exp [5] = '{8'h00, 8'h03, 8'hA1, 8'hB2, 8'hC3};
      logic [7:0] got;
      send_frame(3, 8'hA1, 8'h11, 1'b0);
      wait_cycles(4);
      n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL good_ready got=%b exp=1", obs_ready); end
      for (int i = 0; i < 5; i++) begin
         read_byte(got);
         n_cmp++; if (got !== exp[i]) begin n_fail++; $display("FAIL good_byte%0d got=%h exp=%h", i, got, exp[i]); end
      end
      n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL good_empty got=%b exp=0", obs_ready); end
      n_cmp++; if (obs_drop !== 8'd0)  begin n_fail++; $display("FAIL good_drop got=%h exp=00", obs_drop); end
   endtask

   task automatic test_err_frame();
      logic [7:0] exp [3] = '{8'h00, 8'h01, 8'h5A};
      logic [7:0] got;
      send_frame(3, 8'h11, 8'h11, 1'b1);
      wait_cycles(12);
      send_frame(1, 8'h5A, 8'h00, 1'b0);
      wait_cycles(4);
      n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL err_ready got=%b exp=1", obs_ready); end
      for (int i = 0; i < 3; i++) begin
         read_byte(got);
         n_cmp++; if (got !== exp[i]) begin n_fail++; $display("FAIL err_byte%0d got=%h exp=%h", i, got, exp[i]); end
      end
      n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL err_empty got=%b exp=0", obs_ready); end
      n_cmp++; if (obs_drop !== 8'd1)  begin n_fail++; $display("FAIL err_drop got=%h exp=01", obs_drop); end
   endtask

   task automatic test_read_edge();
      logic [7:0] exp [4] = '{8'h03, 8'h10, 8'h20, 8'h30};
      logic [7:0] got;
      // rising edge while empty: nothing moves
      rd = 1'b1; tick(); rd = 1'b0;
      wait_cycles(4);
      n_cmp++; if (obs_data !== 8'h5A) begin n_fail++; $display("FAIL empty_pop_data got=%h exp=5A", obs_data); end
      n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL empty_pop_ready got=%b exp=0", obs_ready); end
      send_frame(3, 8'h10, 8'h10, 1'b0);
      wait_cycles(4);
      n_cmp++; if (obs_data !== 8'h00) begin n_fail++; $display("FAIL level_head got=%h exp=00", obs_data); end
      // level held high for 10 cycles is a single pop
      rd = 1'b1; wait_cycles(10); rd = 1'b0;
      wait_cycles(4);
      n_cmp++; if (obs_data !== 8'h03) begin n_fail++; $display("FAIL level_one_pop got=%h exp=03", obs_data); end
      for (int i = 0; i < 4; i++) begin
         read_byte(got);
         n_cmp++; if (got !== exp[i]) begin n_fail++; $display("FAIL level_byte%0d got=%h exp=%h", i, got, exp[i]); end
      end
      n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL level_empty got=%b exp=0", obs_ready); end
   endtask

   task automatic test_small_wrap();
      logic [7:0] got;
      logic [7:0] exp;
      sel = 1'b1;
      tick();
      send_frame(10, 8'h01, 8'h01, 1'b0);
      wait_cycles(12);
      send_frame(10, 8'h21, 8'h01, 1'b0);
      wait_cycles(12);
      n_cmp++; if (obs_drop !== 8'd1)  begin n_fail++; $display("FAIL ovf_drop got=%h exp=01", obs_drop); end
      n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_ready got=%b exp=1", obs_ready); end
      for (int i = 0; i < 12; i++) begin
         read_byte(got);
         exp = (i == 0) ? 8'h00 : (i == 1) ? 8'h0A : 8'(i - 1);
         n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL ovf_byte%0d got=%h exp=%h", i, got, exp); end
      end
      n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got=%b exp=0", obs_ready); end
      send_frame(10, 8'h41, 8'h01, 1'b0);
      wait_cycles(4);
      n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_ready got=%b exp=1", obs_ready); end
      for (int i = 0; i < 12; i++) begin
         read_byte(got);
         exp = (i == 0) ? 8'h00 : (i == 1) ? 8'h0A : 8'(8'h3F + i);
         n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL wrap_byte%0d got=%h exp=%h", i, got, exp); end
      end
      n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL wrap_empty got=%b exp=0", obs_ready); end
      n_cmp++; if (obs_drop !== 8'd1)  begin n_fail++; $display("FAIL wrap_drop got=%h exp=01", obs_drop); end
      sel = 1'b0;
      tick();
   endtask

   task automatic test_max_len();
      logic [7:0] exp [5] = '{8'h05, 8'hDC, 8'h00, 8'h01, 8'h02};
      logic [7:0] got;
      send_frame(1501, 8'h00, 8'h01, 1'b0);
      wait_cycles(12);
      n_cmp++; if (obs_drop !== 8'd2)  begin n_fail++; $display("FAIL oversize_drop got=%h exp=02", obs_drop); end
      n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL oversize_ready got=%b exp=0", obs_ready); end
      send_frame(1500, 8'h00, 8'h01, 1'b0);
      wait_cycles(4);
      n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL maxlen_ready got=%b exp=1", obs_ready); end
      for (int i = 0; i < 5; i++) begin
         read_byte(got);
         n_cmp++; if (got !== exp[i]) begin n_fail++; $display("FAIL maxlen_byte%0d got=%h exp=%h", i, got, exp[i]); end
      end
      n_cmp++; if (obs_drop !== 8'd2)  begin n_fail++; $display("FAIL maxlen_drop got=%h exp=02", obs_drop); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp [4] = '{8'h00, 8'h02, 8'h77, 8'h88};
      logic [7:0] got;
      // committed data remains from the previous frame; start another one
      send_byte(8'hE1, 1'b1, 1'b0, 1'b0);
      send_byte(8'hE2, 1'b0, 1'b0, 1'b0);
      send_byte(8'hE3, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      tick();
      n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready got=%b exp=0", obs_ready); end
      n_cmp++; if (obs_drop !== 8'd0)  begin n_fail++; $display("FAIL rstmid_drop got=%h exp=00", obs_drop); end
      reset = 1'b0;
      wait_cycles(2);
      send_frame(2, 8'h77, 8'h11, 1'b0);
      wait_cycles(4);
      n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_new_ready got=%b exp=1", obs_ready); end
      for (int i = 0; i < 4; i++) begin
         read_byte(got);
         n_cmp++; if (got !== exp[i]) begin n_fail++; $display("FAIL rstmid_byte%0d got=%h exp=%h", i, got, exp[i]); end
      end
      n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_empty got=%b exp=0", obs_ready); end
      n_cmp++; if (obs_drop !== 8'd0)  begin n_fail++; $display("FAIL rstmid_final_drop got=%h exp=00", obs_drop); end
   endtask

   initial begin
      reset    = 1'b1;
      in_data  = 8'h00;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_eof   = 1'b0;
      in_err   = 1'b0;
      rd       = 1'b0;
      sel      = 1'b0;
      test_reset();
      test_good_frame();
      test_err_frame();
      test_read_edge();
      test_small_wrap();
      test_max_len();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
